// File: rtl/rgb_pwm_pkg.sv
// Shared definitions for the RGB fade PWM driver: per-channel mode encoding.
package rgb_pwm_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_STATIC  = 2'b01,
    MODE_BREATHE = 2'b10,
    MODE_BLINK   = 2'b11
  } mode_t;

endpackage

// File: rtl/pwm_fade_channel.sv
// One PWM channel: mode/target/level/direction state, the period shadow
// register and the duty comparator against the shared counter.
module pwm_fade_channel
  import rgb_pwm_pkg::*;
#(
  parameter int PWM_BITS  = 8,
  parameter int STEP_SIZE = 1,
  parameter bit INVERT    = 1'b1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                tick,
  input  logic                load,
  input  logic [PWM_BITS-1:0] cnt,
  input  logic                wr_en,
  input  mode_t               wr_mode,
  input  logic [PWM_BITS-1:0] wr_level,
  output logic                pwm
);

  localparam logic [PWM_BITS:0] STEP_EXT = (PWM_BITS + 1)'(STEP_SIZE);

  mode_t               mode, mode_nxt;
  logic [PWM_BITS-1:0] target, target_nxt;
  logic [PWM_BITS-1:0] level, level_nxt;
  logic [PWM_BITS-1:0] shadow;
  logic                dir_down, dir_nxt;
  logic [PWM_BITS:0]   sum;

  // One extra bit so the breathe ramp can never wrap past the target.
  assign sum = {1'b0, level} + STEP_EXT;

  always_comb begin
    mode_nxt   = mode;
    target_nxt = target;
    level_nxt  = level;
    dir_nxt    = dir_down;
    if (wr_en) begin
      mode_nxt   = wr_mode;
      target_nxt = wr_level;
      dir_nxt    = 1'b0;
      level_nxt  = (wr_mode == MODE_STATIC) ? wr_level : '0;
    end else if (tick) begin
      unique case (mode)
        MODE_OFF:    level_nxt = '0;
        MODE_STATIC: level_nxt = target;
        MODE_BREATHE: begin
          if (!dir_down) begin
            if (sum >= {1'b0, target}) begin
              level_nxt = target;
              dir_nxt   = 1'b1;
            end else begin
              level_nxt = sum[PWM_BITS-1:0];
            end
          end else begin
            if ({1'b0, level} <= STEP_EXT) begin
              level_nxt = '0;
              dir_nxt   = 1'b0;
            end else begin
              level_nxt = level - STEP_EXT[PWM_BITS-1:0];
            end
          end
        end
        MODE_BLINK:  level_nxt = (level == '0) ? target : '0;
        default:     level_nxt = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mode     <= MODE_OFF;
      target   <= '0;
      level    <= '0;
      dir_down <= 1'b0;
      shadow   <= '0;
      pwm      <= INVERT;
    end else begin
      mode     <= mode_nxt;
      target   <= target_nxt;
      level    <= level_nxt;
      dir_down <= dir_nxt;
      // Duty only changes at the period boundary so no period is ever cut short.
      if (load) shadow <= level;
      pwm <= (cnt < shadow) ^ INVERT;
    end
  end

endmodule

// File: rtl/rgb_fade_pwm.sv
// Multi-channel PWM LED driver: shared PWM counter and step prescaler,
// config write decode, and one pwm_fade_channel per output.
module rgb_fade_pwm
  import rgb_pwm_pkg::*;
#(
  parameter int CHANNELS  = 3,
  parameter int PWM_BITS  = 8,
  parameter int CH_IDX_W  = 2,
  parameter int STEP_DIV  = 300000,
  parameter int STEP_SIZE = 1,
  parameter bit INVERT    = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_wr_valid,
  output logic                o_wr_ready,
  input  logic [CH_IDX_W-1:0] i_wr_ch,
  input  logic [1:0]          i_wr_mode,
  input  logic [PWM_BITS-1:0] i_wr_level,
  output logic                o_wr_err,
  output logic [CHANNELS-1:0] o_pwm,
  output logic                o_period_start
);

  // Config handshake: a write transfers on every posedge where
  // i_wr_valid && o_wr_ready; o_wr_ready is held high once out of reset.

  localparam int                PS_W     = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PS_W-1:0]   PS_LAST  = PS_W'(STEP_DIV - 1);
  localparam logic [CH_IDX_W:0] CH_LIMIT = (CH_IDX_W + 1)'(CHANNELS);

  logic [PWM_BITS-1:0] cnt;
  logic [PS_W-1:0]     prescaler;
  logic                tick;
  logic                wrap;
  logic                wr_fire;
  logic                wr_ok;

  assign tick    = (prescaler == PS_LAST);
  assign wrap    = &cnt;
  assign wr_fire = i_wr_valid && o_wr_ready;
  assign wr_ok   = wr_fire && ({1'b0, i_wr_ch} < CH_LIMIT);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      cnt            <= '0;
      prescaler      <= '0;
      o_wr_ready     <= 1'b0;
      o_wr_err       <= 1'b0;
      o_period_start <= 1'b0;
    end else begin
      cnt            <= cnt + 1'b1;
      prescaler      <= tick ? '0 : prescaler + 1'b1;
      o_wr_ready     <= 1'b1;
      o_wr_err       <= wr_fire && !wr_ok;
      o_period_start <= (cnt == '0);
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    pwm_fade_channel #(
      .PWM_BITS (PWM_BITS),
      .STEP_SIZE(STEP_SIZE),
      .INVERT   (INVERT)
    ) u_ch (
      .clk     (i_clk),
      .reset_n (i_reset_n),
      .tick    (tick),
      .load    (wrap),
      .cnt     (cnt),
      .wr_en   (wr_ok && (i_wr_ch == CH_IDX_W'(c))),
      .wr_mode (mode_t'(i_wr_mode)),
      .wr_level(i_wr_level),
      .pwm     (o_pwm[c])
    );
  end

endmodule

// File: tb/tb_rgb_fade_pwm.sv
// Directed bench for rgb_fade_pwm: duty per period, glitch-free update,
// breathe/blink level sequences, bad channel index and reset polarity.
module tb_rgb_fade_pwm;
  import rgb_pwm_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       wr_valid;
  logic [1:0] wr_ch;
  logic [1:0] wr_mode;
  logic [3:0] wr_level;
  logic       wr_ready, wr_err, period_start;
  logic [2:0] pwm;
  logic       wr_ready_i, wr_err_i, period_start_i;
  logic [2:0] pwm_i;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  int on_cnt[3];
  int inv_low0;

  always #5 clk = ~clk;

  rgb_fade_pwm #(.CHANNELS(3), .PWM_BITS(4), .CH_IDX_W(2), .STEP_DIV(4),
                 .STEP_SIZE(1), .INVERT(1'b0)) dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_wr_valid(wr_valid), .o_wr_ready(wr_ready),
    .i_wr_ch(wr_ch), .i_wr_mode(wr_mode), .i_wr_level(wr_level), .o_wr_err(wr_err),
    .o_pwm(pwm), .o_period_start(period_start));

  rgb_fade_pwm #(.CHANNELS(3), .PWM_BITS(4), .CH_IDX_W(2), .STEP_DIV(4),
                 .STEP_SIZE(1), .INVERT(1'b1)) dut_inv (
    .i_clk(clk), .i_reset_n(reset_n), .i_wr_valid(wr_valid), .o_wr_ready(wr_ready_i),
    .i_wr_ch(wr_ch), .i_wr_mode(wr_mode), .i_wr_level(wr_level), .o_wr_err(wr_err_i),
    .o_pwm(pwm_i), .o_period_start(period_start_i));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_pop(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s observed=%0d expected=<empty queue>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      check(tag, obs, e);
    end
  endtask

  task automatic write_cmd(input logic [1:0] ch, input mode_t mode, input logic [3:0] lvl);
    wr_valid = 1'b1;
    wr_ch    = ch;
    wr_mode  = mode;
    wr_level = lvl;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic wait_ps();
    int n = 0;
    step();
    while (!period_start && n < 40) begin
      step();
      n++;
    end
    if (!period_start) check("period_start_timeout", 32'(period_start), 32'd1);
  endtask

  // Counts high cycles per channel over the 16 samples starting at the current one.
  task automatic count16();
    for (int c = 0; c < 3; c++) on_cnt[c] = 0;
    inv_low0 = 0;
    for (int j = 0; j < 16; j++) begin
      for (int c = 0; c < 3; c++) on_cnt[c] += int'(pwm[c]);
      inv_low0 += int'(!pwm_i[0]);
      step();
    end
  endtask

  task automatic next_tick();
    int n = 0;
    while (!dut.tick && n < 10) begin
      step();
      n++;
    end
    if (!dut.tick) check("tick_timeout", 32'(dut.tick), 32'd1);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n  = 1'b0;
    wr_valid = 1'b0;
    wr_ch    = '0;
    wr_mode  = '0;
    wr_level = '0;
    repeat (3) step();
    check("rst_pwm", 32'(pwm), 32'd0);
    check("rst_pwm_inv", 32'(pwm_i), 32'd7);
    check("rst_ready", 32'(wr_ready), 32'd0);
    check("rst_ps", 32'(period_start), 32'd0);
    check("rst_err", 32'(wr_err), 32'd0);

    reset_n = 1'b1;
    step();
    check("ready_after_release", 32'(wr_ready), 32'd1);
    check("ps_first", 32'(period_start), 32'd1);
    for (int k = 1; k <= 32; k++) begin
      step();
      check("ps_period16", 32'(period_start), (k % 16 == 0) ? 32'd1 : 32'd0);
    end

    // STATIC duties; each write lands just after a period start.
    write_cmd(2'd0, MODE_STATIC, 4'd5);
    exp_q.push_back(32'd5);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd5);
    wait_ps();
    count16();
    check_pop("static5_ch0", 32'(on_cnt[0]));
    check_pop("static5_ch1_idle", 32'(on_cnt[1]));
    check_pop("static5_inv_low", 32'(inv_low0));

    write_cmd(2'd0, MODE_STATIC, 4'd0);
    exp_q.push_back(32'd0);
    wait_ps();
    count16();
    check_pop("static0_ch0", 32'(on_cnt[0]));

    write_cmd(2'd0, MODE_STATIC, 4'd15);
    exp_q.push_back(32'd15);
    wait_ps();
    count16();
    check_pop("static15_ch0", 32'(on_cnt[0]));

    // Glitch-free update: ch1 at 3/16, then rewritten to 12 at cnt=7.
    write_cmd(2'd1, MODE_STATIC, 4'd3);
    exp_q.push_back(32'd3);
    wait_ps();
    count16();
    check_pop("static3_ch1", 32'(on_cnt[1]));
    check("aligned_ps", 32'(period_start), 32'd1);
    exp_q.push_back(32'd3);
    exp_q.push_back(32'd12);
    on_cnt[1] = 0;
    for (int j = 0; j < 16; j++) begin
      on_cnt[1] += int'(pwm[1]);
      if (j == 6) begin
        check("glitch_write_cnt", 32'(dut.cnt), 32'd7);
        wr_valid = 1'b1;
        wr_ch    = 2'd1;
        wr_mode  = MODE_STATIC;
        wr_level = 4'd12;
      end
      if (j == 7) wr_valid = 1'b0;
      step();
    end
    check_pop("glitch_old_duty", 32'(on_cnt[1]));
    count16();
    check_pop("glitch_new_duty", 32'(on_cnt[1]));

    // BREATHE on ch2 with target 3.
    write_cmd(2'd2, MODE_BREATHE, 4'd3);
    check("breathe_start", 32'(dut.g_ch[2].u_ch.level), 32'd0);
    foreach (exp_q[i]) exp_q.delete(i);
    exp_q.push_back(32'd1); exp_q.push_back(32'd2); exp_q.push_back(32'd3);
    exp_q.push_back(32'd2); exp_q.push_back(32'd1); exp_q.push_back(32'd0);
    exp_q.push_back(32'd1);
    for (int t = 0; t < 7; t++) begin
      next_tick();
      check_pop("breathe_seq", 32'(dut.g_ch[2].u_ch.level));
    end

    // BLINK on ch0 with level 10; ch2 keeps breathing 2,3,2.
    write_cmd(2'd0, MODE_BLINK, 4'd10);
    exp_q.push_back(32'd10); exp_q.push_back(32'd2);
    exp_q.push_back(32'd0);  exp_q.push_back(32'd3);
    exp_q.push_back(32'd10); exp_q.push_back(32'd2);
    for (int t = 0; t < 3; t++) begin
      next_tick();
      check_pop("blink_seq", 32'(dut.g_ch[0].u_ch.level));
      check_pop("breathe_bg", 32'(dut.g_ch[2].u_ch.level));
    end

    // Write to ch2 exactly on a tick edge: write wins, ch0 still toggles.
    while (!dut.tick) step();
    write_cmd(2'd2, MODE_BREATHE, 4'd3);
    check("tick_write_ch2", 32'(dut.g_ch[2].u_ch.level), 32'd0);
    check("tick_write_dir", 32'(dut.g_ch[2].u_ch.dir_down), 32'd0);
    check("tick_other_ch0", 32'(dut.g_ch[0].u_ch.level), 32'd0);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd2);
    next_tick();
    check_pop("restart_seq", 32'(dut.g_ch[2].u_ch.level));
    next_tick();
    check_pop("restart_seq", 32'(dut.g_ch[2].u_ch.level));

    // Out-of-range channel index.
    check("err_idle", 32'(wr_err), 32'd0);
    write_cmd(2'd3, MODE_STATIC, 4'd7);
    check("err_pulse", 32'(wr_err), 32'd1);
    step();
    check("err_single", 32'(wr_err), 32'd0);
    check("bad_ch0_target", 32'(dut.g_ch[0].u_ch.target), 32'd10);
    check("bad_ch1_target", 32'(dut.g_ch[1].u_ch.target), 32'd12);
    check("bad_ch1_level", 32'(dut.g_ch[1].u_ch.level), 32'd12);
    check("bad_ch2_target", 32'(dut.g_ch[2].u_ch.target), 32'd3);
    check("bad_ch2_mode", 32'(dut.g_ch[2].u_ch.mode), 32'(MODE_BREATHE));

    // Reset in the middle of a fade.
    next_tick();
    reset_n = 1'b0;
    step();
    step();
    check("midrst_pwm", 32'(pwm), 32'd0);
    check("midrst_pwm_inv", 32'(pwm_i), 32'd7);
    check("midrst_ready", 32'(wr_ready_i), 32'd0);
    reset_n = 1'b1;
    step();
    check("post_rst_ready", 32'(wr_ready_i), 32'd1);
    check("post_rst_inv_l0", 32'(dut_inv.g_ch[0].u_ch.level), 32'd0);
    check("post_rst_inv_l1", 32'(dut_inv.g_ch[1].u_ch.level), 32'd0);
    check("post_rst_inv_l2", 32'(dut_inv.g_ch[2].u_ch.level), 32'd0);
    check("post_rst_l2", 32'(dut.g_ch[2].u_ch.level), 32'd0);
    check("post_rst_inv_pwm", 32'(pwm_i), 32'd7);
    check("post_rst_ps", 32'(period_start_i), 32'd1);
    check("post_rst_err", 32'(wr_err_i), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
